// File: rtl/busca_instrucao.sv
// busca_instrucao: MIPS instruction-fetch stage holding the PC, fetching over req/ack and selecting the next PC on retire
module busca_instrucao #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [5:0]       OP,
    output logic [5:0]       Funct,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             retire,
    input  logic             Branch,
    input  logic             Zero,
    input  logic             Jump,
    output logic [CNT_W-1:0] retired_count
);
    typedef enum logic [1:0] {IDLE, REQ, EXEC} state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             instr_valid_q;
    logic             imem_req_q;
    logic [CNT_W-1:0] retired_count_q;
    logic [31:0]      next_pc_d;
    logic [31:0]      br_off;

    assign pc_plus4      = pc_q + 32'd4;
    assign br_off        = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign pc            = pc_q;
    assign imem_addr     = pc_q;
    assign imem_req      = imem_req_q;
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign OP            = instr_q[31:26];
    assign Funct         = instr_q[5:0];
    assign retired_count = retired_count_q;

    // Jump outranks a taken branch; an untaken branch falls through to pc+4
    always_comb begin
        next_pc_d = Jump            ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                    (Branch & Zero) ? pc_plus4 + br_off : pc_plus4;
    end

    // Fetch FSM: IDLE -> REQ (wait for ack) -> EXEC (wait for retire) -> REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC & ~32'd3;
            instr_q         <= '0;
            instr_valid_q   <= 1'b0;
            imem_req_q      <= 1'b0;
            retired_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: if (imem_ack) begin
                    instr_q       <= imem_rdata;
                    instr_valid_q <= 1'b1;
                    imem_req_q    <= 1'b0;
                    state_q       <= EXEC;
                end
                EXEC: if (retire) begin
                    pc_q            <= next_pc_d;
                    instr_valid_q   <= 1'b0;
                    retired_count_q <= retired_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    imem_req_q      <= 1'b1;
                    state_q         <= REQ;
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed scoreboard bench for two fetch stages with different reset PCs
module tb_busca_instrucao;
    localparam logic [31:0] RP1 = 32'h1000_0008;
    typedef logic [1:0][31:0] pair_t;

    logic clk = 1'b0, rst = 1'b1, ack = 1'b0, retire = 1'b0, br = 1'b0, zr = 1'b0, jp = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0] req, vld;
    logic [1:0][31:0] addr, ins, pcv, p4, cnt;
    logic [1:0][5:0] op, fn;
    int total = 0, bad = 0;

    pair_t       q_fetch[$];
    logic [31:0] q_instr[$];
    pair_t       q_pc[$];
    logic [31:0] q_cnt[$];

    always #5 clk = ~clk;

    busca_instrucao lo (
        .clk(clk), .rst(rst), .imem_req(req[0]), .imem_addr(addr[0]), .imem_ack(ack),
        .imem_rdata(rdata), .instr(ins[0]), .instr_valid(vld[0]), .OP(op[0]), .Funct(fn[0]),
        .pc(pcv[0]), .pc_plus4(p4[0]), .retire(retire), .Branch(br), .Zero(zr), .Jump(jp),
        .retired_count(cnt[0])
    );

    busca_instrucao #(.RESET_PC(RP1)) hi (
        .clk(clk), .rst(rst), .imem_req(req[1]), .imem_addr(addr[1]), .imem_ack(ack),
        .imem_rdata(rdata), .instr(ins[1]), .instr_valid(vld[1]), .OP(op[1]), .Funct(fn[1]),
        .pc(pcv[1]), .pc_plus4(p4[1]), .retire(retire), .Branch(br), .Zero(zr), .Jump(jp),
        .retired_count(cnt[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic pair_t pr(input logic [31:0] a, input logic [31:0] b);
        pair_t p;
        p[0] = a;
        p[1] = b;
        return p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] w, input int waits);
        int n = 0;
        q_fetch.push_back(pr(a0, a1));
        q_instr.push_back(w);
        while (!req[0] && n < 20) begin
            tick;
            n++;
        end
        chk("fetch_req_seen", {31'b0, req[0]}, 32'd1);
        repeat (waits) tick;
        ack = 1'b1;
        rdata = w;
        tick;
        ack = 1'b0;
        rdata = 32'hA5A5_5A5A;
        chk("valid_after_ack", {31'b0, vld[0]}, 32'd1);
    endtask

    task automatic ret(input logic b, input logic z, input logic j,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] c);
        int n = 0;
        q_pc.push_back(pr(e0, e1));
        q_cnt.push_back(c);
        while (!vld[0] && n < 20) begin
            tick;
            n++;
        end
        chk("retire_valid_seen", {31'b0, vld[0]}, 32'd1);
        br = b;
        zr = z;
        jp = j;
        retire = 1'b1;
        tick;
        retire = 1'b0;
        br = 1'b0;
        zr = 1'b0;
        jp = 1'b0;
    endtask

    logic        req_p = 1'b0, vld_p = 1'b0;
    pair_t       a_hold, e_m;
    logic [31:0] i_hold, w_m, c_m;

    always @(negedge clk) begin
        if (req[0] && !req_p) begin
            if (q_fetch.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_fetch: got addr %h want none", addr[0]);
            end else begin
                e_m = q_fetch.pop_front();
                chk("fetch_addr_lo", addr[0], e_m[0]);
                chk("fetch_addr_hi", addr[1], e_m[1]);
            end
            a_hold = addr;
        end else if (req[0]) begin
            chk("addr_hold_lo", addr[0], a_hold[0]);
            chk("addr_hold_hi", addr[1], a_hold[1]);
        end
        if (req[0]) chk("valid_low_in_req", {31'b0, vld[0]}, 32'd0);
        if (vld[0] && !vld_p) begin
            if (q_instr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got %h want none", ins[0]);
            end else begin
                w_m = q_instr.pop_front();
                chk("instr_lo", ins[0], w_m);
                chk("instr_hi", ins[1], w_m);
                chk("op_lo", {26'b0, op[0]}, {26'b0, w_m[31:26]});
                chk("funct_lo", {26'b0, fn[0]}, {26'b0, w_m[5:0]});
                chk("op_hi", {26'b0, op[1]}, {26'b0, w_m[31:26]});
                chk("funct_hi", {26'b0, fn[1]}, {26'b0, w_m[5:0]});
            end
            i_hold = ins[0];
        end else if (vld[0]) begin
            chk("instr_hold_lo", ins[0], i_hold);
            chk("instr_hold_hi", ins[1], i_hold);
        end
        if (!vld[0] && vld_p) begin
            if (q_pc.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got pc %h want none", pcv[0]);
            end else begin
                e_m = q_pc.pop_front();
                c_m = q_cnt.pop_front();
                chk("pc_lo", pcv[0], e_m[0]);
                chk("pc_hi", pcv[1], e_m[1]);
                chk("pc4_lo", p4[0], e_m[0] + 32'd4);
                chk("pc4_hi", p4[1], e_m[1] + 32'd4);
                chk("count_lo", cnt[0], c_m);
                chk("count_hi", cnt[1], c_m);
            end
        end
        req_p = req[0];
        vld_p = vld[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tick;
        tick;
        chk("rst_req", {31'b0, req[0]}, 32'd0);
        chk("rst_valid", {31'b0, vld[0]}, 32'd0);
        chk("rst_pc_lo", pcv[0], 32'h0);
        chk("rst_pc_hi", pcv[1], RP1);
        chk("rst_count", cnt[0], 32'd0);
        chk("rst_instr", ins[0], 32'd0);
        chk("rst_op", {26'b0, op[0]}, 32'd0);
        chk("rst_funct", {26'b0, fn[0]}, 32'd0);
        rst = 1'b0;
        chk("idle_no_req", {31'b0, req[0]}, 32'd0);
        tick;
        chk("req_one_after_rst", {31'b0, req[0]}, 32'd1);
        fetch(32'h0, RP1, 32'h0000_0020, 0);
        ret(1'b0, 1'b0, 1'b0, 32'h4, 32'h1000_000C, 32'd1);
        fetch(32'h4, 32'h1000_000C, 32'h0800_0010, 3);
        ack = 1'b1;
        rdata = 32'hDEAD_BEEF;
        tick;
        ack = 1'b0;
        ret(1'b1, 1'b1, 1'b1, 32'h40, 32'h1000_0040, 32'd2);
        fetch(32'h40, 32'h1000_0040, 32'h1000_FFFE, 0);
        ret(1'b1, 1'b1, 1'b0, 32'h3C, 32'h1000_003C, 32'd3);
        fetch(32'h3C, 32'h1000_003C, 32'h0800_0010, 1);
        ret(1'b0, 1'b0, 1'b1, 32'h40, 32'h1000_0040, 32'd4);
        fetch(32'h40, 32'h1000_0040, 32'h1000_FFFE, 2);
        ret(1'b1, 1'b0, 1'b0, 32'h44, 32'h1000_0044, 32'd5);
        fetch(32'h44, 32'h1000_0044, 32'h1000_FFED, 0);
        ret(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 32'd6);
        fetch(32'hFFFF_FFFC, 32'h0FFF_FFFC, 32'h0000_0020, 0);
        ret(1'b0, 1'b1, 1'b0, 32'h0, 32'h1000_0000, 32'd7);
        q_fetch.push_back(pr(32'h0, 32'h1000_0000));
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_req", {31'b0, req[0]}, 32'd0);
        chk("midrst_valid", {31'b0, vld[0]}, 32'd0);
        chk("midrst_pc_lo", pcv[0], 32'h0);
        chk("midrst_pc_hi", pcv[1], RP1);
        chk("midrst_count", cnt[0], 32'd0);
        ack = 1'b1;
        rdata = 32'hFFFF_FFFF;
        tick;
        ack = 1'b0;
        chk("late_ack_instr", ins[0], 32'd0);
        chk("late_ack_valid", {31'b0, vld[0]}, 32'd0);
        fetch(32'h0, RP1, 32'h0800_0010, 0);
        ret(1'b1, 1'b1, 1'b1, 32'h40, 32'h1000_0040, 32'd1);
        q_fetch.push_back(pr(32'h40, 32'h1000_0040));
        repeat (3) tick;
        chk("fetch_q_empty", 32'(q_fetch.size()), 32'd0);
        chk("instr_q_empty", 32'(q_instr.size()), 32'd0);
        chk("pc_q_empty", 32'(q_pc.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
